// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling slice.
package rc4_pkg;

   localparam int unsigned DEFAULT_KEY_LENGTH = 3;

   // ramcontroller device-select code for the KSA stage
   localparam logic [2:0] MODE_KSA = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      READ_I,
      LATCH_I,
      READ_J,
      LATCH_J,
      WRITE_I,
      WRITE_J,
      DONE
   } ksa_state_t;

endpackage

// File: rtl/ksa_swapper_if.sv
// Start/finished handshake plus single-port RAM bus between ramcontroller and ksa_swapper.
interface ksa_swapper_if #(
   parameter int unsigned RAM_WIDTH = 8
);
   logic                 start;
   logic                 finished;
   logic                 write_enable;
   logic [RAM_WIDTH-1:0] ram_in;
   logic [RAM_WIDTH-1:0] address;
   logic [RAM_WIDTH-1:0] ram_out;

   // controller side: issues start, returns RAM read data
   modport master (
      output start,
      output ram_out,
      input  finished,
      input  write_enable,
      input  ram_in,
      input  address
   );

   // KSA side: drives the RAM port, reports completion
   modport slave (
      input  start,
      input  ram_out,
      output finished,
      output write_enable,
      output ram_in,
      output address
   );
endinterface

// File: rtl/ksa_key_selector.sv
// Latched secret key with a wrapping byte index; presents key[i mod KEY_LENGTH].
module ksa_key_selector #(
   parameter int unsigned KEY_LENGTH = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    clear,
   input  logic                    advance,
   input  logic [8*KEY_LENGTH-1:0] secret_key,
   output logic [7:0]              key_byte
);
   localparam int unsigned K_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(KEY_LENGTH - 1);

   logic [8*KEY_LENGTH-1:0] key_q, key_d;
   logic [K_W-1:0]          k_q, k_d;

   // key latch and wrap counter (k stands in for i mod KEY_LENGTH)
   always_comb begin
      key_d = key_q;
      k_d   = k_q;
      if (load) begin
         key_d = secret_key;
      end
      if (clear) begin
         k_d = '0;
      end else if (advance) begin
         k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_q <= '0;
         k_q   <= '0;
      end else begin
         key_q <= key_d;
         k_q   <= k_d;
      end
   end

   // byte mux; byte 0 is the most significant byte of the key
   always_comb begin
      key_byte = '0;
      for (int unsigned b = 0; b < KEY_LENGTH; b++) begin
         if (k_q == K_W'(b)) begin
            key_byte = key_q[8*(KEY_LENGTH-1-b) +: 8];
         end
      end
   end
endmodule

// File: rtl/ksa_swapper.sv
// RC4 key-scheduling stage: j += S[i] + key[i mod L], swap S[i] and S[j], for every i.
module ksa_swapper
   import rc4_pkg::*;
#(
   parameter int unsigned RAM_WIDTH  = 8,
   parameter int unsigned RAM_SIZE   = 256,
   parameter int unsigned KEY_LENGTH = DEFAULT_KEY_LENGTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [8*KEY_LENGTH-1:0] secret_key,
   ksa_swapper_if.slave            bus
);
   localparam logic [RAM_WIDTH-1:0] LAST_I = RAM_WIDTH'(RAM_SIZE - 1);

   ksa_state_t           state_q, state_d;
   logic [RAM_WIDTH-1:0] i_q, i_d;
   logic [RAM_WIDTH-1:0] j_q, j_d;
   logic [RAM_WIDTH-1:0] si_q, si_d;
   logic [RAM_WIDTH-1:0] sj_q, sj_d;

   logic       key_load;
   logic       key_advance;
   logic [7:0] key_byte;

   assign key_load    = (state_q == IDLE) && bus.start;
   assign key_advance = (state_q == WRITE_J) && (i_q != LAST_I);

   ksa_key_selector #(
      .KEY_LENGTH (KEY_LENGTH)
   ) u_key_sel (
      .clk        (clk),
      .reset      (reset),
      .load       (key_load),
      .clear      (key_load),
      .advance    (key_advance),
      .secret_key (secret_key),
      .key_byte   (key_byte)
   );

   // next-state and datapath updates
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               i_d     = '0;
               j_d     = '0;
               state_d = READ_I;
            end
         end
         READ_I:  state_d = LATCH_I;
         LATCH_I: begin
            si_d    = bus.ram_out;
            j_d     = j_q + bus.ram_out + RAM_WIDTH'(key_byte);
            state_d = READ_J;
         end
         READ_J:  state_d = LATCH_J;
         LATCH_J: begin
            sj_d    = bus.ram_out;
            state_d = WRITE_I;
         end
         WRITE_I: state_d = WRITE_J;
         WRITE_J: begin
            if (i_q == LAST_I) begin
               state_d = DONE;
            end else begin
               i_d     = i_q + 1'b1;
               state_d = READ_I;
            end
         end
         DONE: begin
            if (!bus.start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
      end
   end

   // RAM port and handshake decoded purely from registered state
   always_comb begin
      bus.address      = '0;
      bus.ram_in       = '0;
      bus.write_enable = 1'b0;
      bus.finished     = 1'b0;
      unique case (state_q)
         READ_I:  bus.address = i_q;
         READ_J:  bus.address = j_q;
         WRITE_I: begin
            bus.address      = i_q;
            bus.ram_in       = sj_q;
            bus.write_enable = 1'b1;
         end
         WRITE_J: begin
            bus.address      = j_q;
            bus.ram_in       = si_q;
            bus.write_enable = 1'b1;
         end
         DONE:    bus.finished = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_ksa_swapper.sv
// Self-checking bench for ksa_swapper: behavioural RAMs, golden KSA model, vector table.
module tb_ksa_swapper;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] key1;
   logic [39:0] key2;
   logic        init1, init2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ksa_swapper_if #(.RAM_WIDTH(8)) bus1 ();
   ksa_swapper_if #(.RAM_WIDTH(8)) bus2 ();

   ksa_swapper #(.RAM_WIDTH(8), .RAM_SIZE(256), .KEY_LENGTH(3)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .secret_key (key1),
      .bus        (bus1)
   );

   ksa_swapper #(.RAM_WIDTH(8), .RAM_SIZE(256), .KEY_LENGTH(5)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .secret_key (key2),
      .bus        (bus2)
   );

   // behavioural synchronous RAMs with a write log
   logic [7:0] mem1 [256];
   logic [7:0] mem2 [256];
   logic [7:0] la1 [512];
   logic [7:0] ld1 [512];
   int unsigned wcnt1, wcnt2;

   always @(posedge clk) begin
      if (init1) begin
         for (int i = 0; i < 256; i++) mem1[i] <= 8'(i);
         wcnt1 <= 0;
      end else if (bus1.write_enable) begin
         mem1[bus1.address] <= bus1.ram_in;
         if (wcnt1 < 512) begin
            la1[wcnt1] <= bus1.address;
            ld1[wcnt1] <= bus1.ram_in;
         end
         wcnt1 <= wcnt1 + 1;
      end
      bus1.ram_out <= mem1[bus1.address];
   end

   always @(posedge clk) begin
      if (init2) begin
         for (int i = 0; i < 256; i++) mem2[i] <= 8'(i);
         wcnt2 <= 0;
      end else if (bus2.write_enable) begin
         mem2[bus2.address] <= bus2.ram_in;
         wcnt2 <= wcnt2 + 1;
      end
      bus2.ram_out <= mem2[bus2.address];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // golden KSA straight from the algorithm definition
   task automatic check_mem(input string nm, input logic [7:0] m [256],
                            input logic [39:0] key, input int len);
      int s [256];
      int j = 0;
      int t, bad = 0, first = -1;
      for (int i = 0; i < 256; i++) s[i] = i;
      for (int i = 0; i < 256; i++) begin
         j = (j + s[i] + int'(key[8*(len-1-(i % len)) +: 8])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
      end
      for (int i = 0; i < 256; i++) begin
         if (int'(m[i]) != s[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      if (bad != 0) $display("note %s: first differing S index %0d", nm, first);
      chk({nm, " S mismatches"}, 64'(bad), 64'd0);
   endtask

   task automatic start_run(input int d, input logic [39:0] key);
      @(negedge clk);
      if (d == 1) init1 = 1'b1; else init2 = 1'b1;
      @(negedge clk);
      init1 = 1'b0;
      init2 = 1'b0;
      if (d == 1) begin key1 = key[23:0]; bus1.start = 1'b1; end
      else        begin key2 = key;       bus2.start = 1'b1; end
      @(posedge clk);
   endtask

   // edges after the start-sampling edge until finished is seen (bounded)
   task automatic wait_done(input int d, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (((d == 1) ? !bus1.finished : !bus2.finished) && n < 2000);
   endtask

   task automatic end_run(input int d);
      @(negedge clk);
      if (d == 1) bus1.start = 1'b0; else bus2.start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic full_run(input int d, input logic [39:0] key, input int len, input string nm);
      int n;
      start_run(d, key);
      wait_done(d, n);
      chk({nm, " finished edge"}, 64'(n), 64'd1536);
      if (d == 1) begin
         chk({nm, " writes"}, 64'(wcnt1), 64'd512);
         check_mem(nm, mem1, key, len);
      end else begin
         chk({nm, " writes"}, 64'(wcnt2), 64'd512);
         check_mem(nm, mem2, key, len);
      end
      end_run(d);
   endtask

   typedef struct {
      logic [23:0] key;
      int          iter;
      logic [7:0]  a0, d0, a1, d1;
   } vec_t;

   vec_t        vt [7];
   logic [23:0] kt [3];

   initial begin
      int n;
      logic [39:0] rk;
      logic        held;

      vt[0] = '{24'h000000, 0, 8'd0,  8'd0,   8'd0,   8'd0};
      vt[1] = '{24'h000000, 1, 8'd1,  8'd1,   8'd1,   8'd1};
      vt[2] = '{24'h000000, 2, 8'd2,  8'd3,   8'd3,   8'd2};
      vt[3] = '{24'h010203, 0, 8'd0,  8'd1,   8'd1,   8'd0};
      vt[4] = '{24'h010203, 1, 8'd1,  8'd3,   8'd3,   8'd0};
      vt[5] = '{24'hFFFFFF, 0, 8'd0,  8'd255, 8'd255, 8'd0};
      vt[6] = '{24'hFFFFFF, 1, 8'd1,  8'd0,   8'd255, 8'd1};
      kt[0] = 24'h000000;
      kt[1] = 24'h010203;
      kt[2] = 24'hFFFFFF;

      reset = 1'b0;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      key1 = '0;
      key2 = '0;
      init1 = 1'b0;
      init2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset finished",     64'(bus1.finished),     64'd0);
      chk("reset write_enable", 64'(bus1.write_enable), 64'd0);
      chk("reset address",      64'(bus1.address),      64'd0);
      chk("reset ram_in",       64'(bus1.ram_in),       64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("idle address", 64'(bus1.address), 64'd0);

      // fixed keys with per-iteration write checks
      for (int k = 0; k < 3; k++) begin
         full_run(1, 40'(kt[k]), 3, $sformatf("key %06h", kt[k]));
         for (int r = 0; r < 7; r++) begin
            if (vt[r].key == kt[k]) begin
               chk($sformatf("key %06h it%0d wr_i addr", kt[k], vt[r].iter), 64'(la1[2*vt[r].iter]),   64'(vt[r].a0));
               chk($sformatf("key %06h it%0d wr_i data", kt[k], vt[r].iter), 64'(ld1[2*vt[r].iter]),   64'(vt[r].d0));
               chk($sformatf("key %06h it%0d wr_j addr", kt[k], vt[r].iter), 64'(la1[2*vt[r].iter+1]), 64'(vt[r].a1));
               chk($sformatf("key %06h it%0d wr_j data", kt[k], vt[r].iter), 64'(ld1[2*vt[r].iter+1]), 64'(vt[r].d1));
            end
         end
      end

      // random keys
      for (int r = 0; r < 3; r++) begin
         rk = 40'($urandom) & 40'hFF_FFFF;
         full_run(1, rk, 3, $sformatf("rand key %06h", rk[23:0]));
      end

      // asynchronous reset in the middle of a write
      start_run(1, 40'hA1B2C3);
      repeat (700) begin @(posedge clk); #1; end
      chk("pre-reset write_enable", 64'(bus1.write_enable), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("async reset write_enable", 64'(bus1.write_enable), 64'd0);
      chk("async reset address",      64'(bus1.address),      64'd0);
      chk("async reset ram_in",       64'(bus1.ram_in),       64'd0);
      chk("async reset finished",     64'(bus1.finished),     64'd0);
      bus1.start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      full_run(1, 40'hA1B2C3, 3, "post-reset rerun");

      // start held through DONE, mid-run start/key glitches, then restart
      start_run(1, 40'h5A3C7E);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 300) begin key1 = 24'h13579B; bus1.start = 1'b0; end
         if (n == 302) bus1.start = 1'b1;
      end while (!bus1.finished && n < 2000);
      chk("held-start finished edge", 64'(n), 64'd1536);
      held = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (!bus1.finished) held = 1'b0;
      end
      chk("finished held in DONE", 64'(held), 64'd1);
      chk("no retrigger writes", 64'(wcnt1), 64'd512);
      check_mem("key change ignored", mem1, 40'h5A3C7E, 3);
      end_run(1);
      chk("finished after start drop", 64'(bus1.finished), 64'd0);
      full_run(1, 40'h13579B, 3, "second run");

      // five-byte key instance
      full_run(2, 40'h0102030405, 5, "len5 key 0102030405");
      rk = {8'($urandom), 32'($urandom)};
      full_run(2, rk, 5, $sformatf("len5 rand key %010h", rk));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
